// File: rtl/divider_if.sv
// Handshake and operand/result bundle between the EX stage and the iterative divider.
interface divider_if #(
   parameter int unsigned XLEN = 64
);
   logic            start_i;
   logic [1:0]      op_i;
   logic            word_i;
   logic [XLEN-1:0] dividend_i;
   logic [XLEN-1:0] divisor_i;
   logic            flush_i;
   logic            busy_o;
   logic            done_o;
   logic [XLEN-1:0] result_o;

   modport slave (
      input  start_i, op_i, word_i, dividend_i, divisor_i, flush_i,
      output busy_o, done_o, result_o
   );

   modport master (
      output start_i, op_i, word_i, dividend_i, divisor_i, flush_i,
      input  busy_o, done_o, result_o
   );
endinterface

// File: rtl/divider.sv
// Iterative restoring divider for RV64M DIV/DIVU/REM/REMU and their W variants.
// One quotient bit per cycle; divide-by-zero and signed overflow resolve in one cycle.
module divider #(
   parameter int unsigned XLEN = 64
) (
   input  logic     clk,
   input  logic     rst_n,
   divider_if.slave bus
);
   localparam int unsigned WLEN  = 32;
   localparam int unsigned CNT_W = 6;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

   state_e          state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dsr_q, dsr_d, result_q, result_d;
   logic [1:0]      op_q, op_d;
   logic            word_q, word_d, qneg_q, qneg_d, rneg_q, rneg_d, done_q, done_d;

   // Operand extension, magnitudes and special-case detection at issue time
   logic            is_signed, a_neg, b_neg, div_zero, ovf;
   logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_neg, dvd_op, spec_res;

   always_comb begin
      is_signed = ~bus.op_i[0];
      if (bus.word_i) begin
         a_ext   = {{(XLEN-WLEN){bus.dividend_i[WLEN-1] & is_signed}}, bus.dividend_i[WLEN-1:0]};
         b_ext   = {{(XLEN-WLEN){bus.divisor_i[WLEN-1] & is_signed}}, bus.divisor_i[WLEN-1:0]};
         min_neg = {{(XLEN-WLEN){1'b1}}, 1'b1, {(WLEN-1){1'b0}}};
         dvd_op  = {{(XLEN-WLEN){bus.dividend_i[WLEN-1]}}, bus.dividend_i[WLEN-1:0]};
      end else begin
         a_ext   = bus.dividend_i;
         b_ext   = bus.divisor_i;
         min_neg = {1'b1, {(XLEN-1){1'b0}}};
         dvd_op  = bus.dividend_i;
      end
      a_neg    = is_signed & a_ext[XLEN-1];
      b_neg    = is_signed & b_ext[XLEN-1];
      a_mag    = a_neg ? -a_ext : a_ext;
      b_mag    = b_neg ? -b_ext : b_ext;
      div_zero = (b_ext == '0);
      ovf      = is_signed && (a_ext == min_neg) && (b_ext == '1);
      if (div_zero) spec_res = bus.op_i[1] ? dvd_op : '1;
      else          spec_res = bus.op_i[1] ? '0 : dvd_op;
   end

   // One restoring shift-subtract step and final sign/width fix-up
   logic [XLEN:0]   rem_sh;
   logic            ge;
   logic [XLEN-1:0] rem_nx, quo_nx, q_fin, r_fin, val_fin, res_fin;
   logic [CNT_W-1:0] last_cnt;

   always_comb begin
      rem_sh   = {rem_q, quo_q[XLEN-1]};
      ge       = (rem_sh >= {1'b0, dsr_q});
      rem_nx   = ge ? XLEN'(rem_sh - {1'b0, dsr_q}) : rem_sh[XLEN-1:0];
      quo_nx   = {quo_q[XLEN-2:0], ge};
      q_fin    = qneg_q ? -quo_nx : quo_nx;
      r_fin    = rneg_q ? -rem_nx : rem_nx;
      val_fin  = op_q[1] ? r_fin : q_fin;
      res_fin  = word_q ? {{(XLEN-WLEN){val_fin[WLEN-1]}}, val_fin[WLEN-1:0]} : val_fin;
      last_cnt = word_q ? CNT_W'(WLEN-1) : CNT_W'(XLEN-1);
   end

   // Next-state and datapath register updates
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      quo_d    = quo_q;
      rem_d    = rem_q;
      dsr_d    = dsr_q;
      result_d = result_q;
      op_d     = op_q;
      word_d   = word_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      done_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start_i && !bus.flush_i) begin
               if (div_zero || ovf) begin
                  result_d = spec_res;
                  done_d   = 1'b1;
                  state_d  = DONE;
               end else begin
                  quo_d   = bus.word_i ? XLEN'({a_mag[WLEN-1:0], {WLEN{1'b0}}}) : a_mag;
                  rem_d   = '0;
                  dsr_d   = b_mag;
                  op_d    = bus.op_i;
                  word_d  = bus.word_i;
                  qneg_d  = a_neg ^ b_neg;
                  rneg_d  = a_neg;
                  cnt_d   = '0;
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            quo_d = quo_nx;
            rem_d = rem_nx;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == last_cnt) begin
               result_d = res_fin;
               done_d   = 1'b1;
               state_d  = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (bus.flush_i) begin
         state_d = IDLE;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         quo_q    <= '0;
         rem_q    <= '0;
         dsr_q    <= '0;
         result_q <= '0;
         op_q     <= '0;
         word_q   <= 1'b0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         quo_q    <= quo_d;
         rem_q    <= rem_d;
         dsr_q    <= dsr_d;
         result_q <= result_d;
         op_q     <= op_d;
         word_q   <= word_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         done_q   <= done_d;
      end
   end

   // busy_o is a same-cycle stall request, so it is deliberately combinational
   assign bus.busy_o   = ((state_q == IDLE) && bus.start_i && !bus.flush_i) || (state_q == CALC);
   assign bus.done_o   = done_q;
   assign bus.result_o = result_q;
endmodule

// File: tb/tb_divider.sv
// Randomized self-checking bench for divider against an arithmetic reference model.
module tb_divider;
   localparam int unsigned XLEN = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   divider_if #(.XLEN(XLEN)) bus ();
   divider #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
      end
   endtask

   // RISC-V M-extension semantics, computed directly with language arithmetic
   function automatic logic [63:0] ref_result(input logic [1:0] op, input logic w,
                                              input logic [63:0] a, input logic [63:0] b);
      logic [31:0] a32, b32, r32;
      logic [63:0] r64;
      a32 = a[31:0];
      b32 = b[31:0];
      if (w) begin
         if (b32 == 32'd0) r32 = op[1] ? a32 : 32'hFFFF_FFFF;
         else if (!op[0] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = op[1] ? 32'd0 : a32;
         else begin
            case (op)
               2'd0:    r32 = $signed(a32) / $signed(b32);
               2'd1:    r32 = a32 / b32;
               2'd2:    r32 = $signed(a32) % $signed(b32);
               default: r32 = a32 % b32;
            endcase
         end
         return {{32{r32[31]}}, r32};
      end
      if (b == 64'd0) r64 = op[1] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
      else if (!op[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) r64 = op[1] ? 64'd0 : a;
      else begin
         case (op)
            2'd0:    r64 = $signed(a) / $signed(b);
            2'd1:    r64 = a / b;
            2'd2:    r64 = $signed(a) % $signed(b);
            default: r64 = a % b;
         endcase
      end
      return r64;
   endfunction

   function automatic int ref_latency(input logic [1:0] op, input logic w,
                                      input logic [63:0] a, input logic [63:0] b);
      bit spec;
      if (w) spec = (b[31:0] == 32'd0) || (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
      else   spec = (b == 64'd0) || (!op[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF);
      return spec ? 1 : (w ? 33 : 65);
   endfunction

   // Issue one op at the next negedge (cycle 0) and follow it to done_o
   task automatic run_op(input string tag, input logic [1:0] op, input logic w,
                         input logic [63:0] a, input logic [63:0] b, input bit drop_start);
      int lat, cyc, busy_cnt;
      bit seen;
      lat = ref_latency(op, w, a, b);
      @(negedge clk);
      bus.start_i    = 1'b1;
      bus.op_i       = op;
      bus.word_i     = w;
      bus.dividend_i = a;
      bus.divisor_i  = b;
      #1;
      check({tag, " done_at_c0"}, 64'(bus.done_o), 64'd0);
      busy_cnt = int'(bus.busy_o);
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (drop_start && cyc == 5) bus.start_i = 1'b0;
         busy_cnt += int'(bus.busy_o);
         if (bus.done_o) seen = 1'b1;
      end
      check({tag, " done_cycle"}, seen ? 64'(cyc) : 64'hFFFF_FFFF_FFFF_FFFF, 64'(lat));
      check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(lat));
      check({tag, " result"}, bus.result_o, ref_result(op, w, a, b));
      bus.start_i = 1'b0;
   endtask

   logic [63:0] ra, rb;
   logic [1:0]  rop;
   logic        rw;
   int          pulses;

   initial begin
      bus.start_i    = 1'b0;
      bus.op_i       = 2'd0;
      bus.word_i     = 1'b0;
      bus.dividend_i = '0;
      bus.divisor_i  = '0;
      bus.flush_i    = 1'b0;
      repeat (3) @(negedge clk);
      check("reset done", 64'(bus.done_o), 64'd0);
      check("reset busy", 64'(bus.busy_o), 64'd0);
      check("reset result", bus.result_o, 64'd0);
      rst_n = 1'b1;

      run_op("DIV 100/-7", 2'd0, 1'b0, 64'd100, -64'd7, 1'b0);
      run_op("REM -100/7", 2'd2, 1'b0, -64'd100, 64'd7, 1'b0);
      run_op("REMU 100/7", 2'd3, 1'b0, 64'd100, 64'd7, 1'b0);
      run_op("DIVU x/0", 2'd1, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'd0, 1'b0);
      run_op("REM 5/0", 2'd2, 1'b0, 64'd5, 64'd0, 1'b0);
      run_op("DIV ovf", 2'd0, 1'b0, 64'h8000_0000_0000_0000, -64'd1, 1'b0);
      run_op("REMW ovf", 2'd2, 1'b1, 64'h0000_0000_8000_0000, -64'd1, 1'b0);
      run_op("DIVUW ffffffff/1", 2'd1, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0);
      run_op("REMUW x/0", 2'd3, 1'b1, 64'hABCD_0000_9000_0001, 64'hFFFF_FFFF_0000_0000, 1'b0);
      run_op("DIV start drop", 2'd0, 1'b0, -64'd123456789, 64'd1000, 1'b1);

      // Flush at cycle 10 of a DIV, restart at cycle 12
      @(negedge clk);
      bus.start_i = 1'b1; bus.op_i = 2'd0; bus.word_i = 1'b0;
      bus.dividend_i = 64'd1000; bus.divisor_i = 64'd3;
      pulses = 0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         pulses += int'(bus.done_o);
      end
      bus.flush_i = 1'b1; bus.start_i = 1'b0;
      @(negedge clk);
      bus.flush_i = 1'b0;
      pulses += int'(bus.done_o);
      #1;
      check("flush idle busy", 64'(bus.busy_o), 64'd0);
      check("flush no done", 64'(pulses), 64'd0);
      run_op("DIV after flush", 2'd0, 1'b0, 64'd1000, 64'd3, 1'b0);

      // Flush beats start in IDLE
      @(negedge clk);
      bus.start_i = 1'b1; bus.flush_i = 1'b1;
      #1;
      check("flush prio busy", 64'(bus.busy_o), 64'd0);
      @(negedge clk);
      bus.start_i = 1'b0; bus.flush_i = 1'b0;
      #1;
      check("flush prio state", 64'(bus.busy_o), 64'd0);

      // Reset mid-CALC abandons the operation
      @(negedge clk);
      bus.start_i = 1'b1; bus.op_i = 2'd1; bus.word_i = 1'b0;
      bus.dividend_i = 64'd999; bus.divisor_i = 64'd7;
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst done", 64'(bus.done_o), 64'd0);
      check("rst result", bus.result_o, 64'd0);
      check("rst busy follows start", 64'(bus.busy_o), 64'd1);
      bus.start_i = 1'b0;
      #1;
      check("rst busy idle", 64'(bus.busy_o), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         pulses += int'(bus.done_o);
      end
      check("rst no done", 64'(pulses), 64'd0);

      // Randomized ops, biased toward the special cases
      for (int i = 0; i < 40; i++) begin
         rop = 2'($urandom_range(0, 3));
         rw  = 1'($urandom_range(0, 1));
         ra  = {$urandom, $urandom} >> $urandom_range(0, 63);
         if ($urandom_range(0, 1) == 1) ra = -ra;
         rb  = {$urandom, $urandom} >> $urandom_range(0, 63);
         case ($urandom_range(0, 7))
            0: rb = rw ? {$urandom, 32'd0} : 64'd0;
            1: begin
               ra = rw ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
               rb = rw ? {$urandom, 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
            end
            2: rb = 64'($urandom_range(1, 20));
            default: ;
         endcase
         run_op($sformatf("rand%0d op%0d w%0d", i, rop, rw), rop, rw, ra, rb, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
